// File: rtl/enc_pkg.sv
// Shared constants for the Pmod ENC encoder bank: step direction, counter mode,
// debounced-pin indices and the default bounds for the 160x120 cursor/colour knobs.
package enc_pkg;
    localparam logic DIR_INC   = 1'b0;
    localparam logic DIR_DEC   = 1'b1;
    localparam logic MODE_SAT  = 1'b0;
    localparam logic MODE_WRAP = 1'b1;

    localparam int P_A   = 0;
    localparam int P_B   = 1;
    localparam int P_BTN = 2;
    localparam int P_SWT = 3;

    // Channel 0 is cursor x (159), channel 1 cursor y (119), channel 2 colour (255).
    localparam int          SCR_CH  = 3;
    localparam logic [23:0] SCR_MAX = {8'd255, 8'd119, 8'd159};
endpackage

// File: rtl/enc_channel.sv
// One encoder channel: synchronise and debounce A/B/BTN/SWT, decode one step per
// A rising edge, and keep a bounded wrapping or saturating position counter.
module enc_channel
    import enc_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] MAX        = 8'd159,
    parameter logic [WIDTH-1:0] INIT       = '0,
    parameter logic             WRAP       = MODE_SAT,
    parameter int               DEB_CYCLES = 5000,
    parameter int               FAST_STEP  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             btn,
    input  logic             swt,
    output logic [WIDTH-1:0] pos,
    output logic             changed,
    output logic             btn_evt
);
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [WIDTH:0] M_EXT    = {1'b0, MAX};
    localparam logic [WIDTH:0] MOD      = {1'b0, MAX} + (WIDTH+1)'(1);

    logic [3:0]         sync1, sync2, deb;
    logic [3:0][CW-1:0] cnt;
    logic               a_q, btn_q;
    logic               a_rise, btn_rise;
    logic [WIDTH:0]     p, s, sum, step_val;
    logic [WIDTH-1:0]   nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {swt, btn, b, a};
            sync2 <= sync1;
        end
    end

    // Debounced value only moves after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            deb <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign a_rise   = deb[P_A] & ~a_q;
    assign btn_rise = deb[P_BTN] & ~btn_q;

    always_comb begin
        p        = {1'b0, pos};
        s        = deb[P_SWT] ? (WIDTH+1)'(FAST_STEP) : (WIDTH+1)'(1);
        sum      = p + s;
        step_val = p;
        case (deb[P_B])
            DIR_INC: begin
                if (sum > M_EXT) step_val = (WRAP == MODE_WRAP) ? sum - MOD : M_EXT;
                else             step_val = sum;
            end
            DIR_DEC: begin
                if (p < s) step_val = (WRAP == MODE_SAT) ? '0 : p + MOD - s;
                else       step_val = p - s;
            end
            default: step_val = p;
        endcase
        nxt = pos;
        if (btn_rise)    nxt = INIT;
        else if (a_rise) nxt = step_val[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= 1'b0;
            btn_q   <= 1'b0;
            pos     <= INIT;
            changed <= 1'b0;
            btn_evt <= 1'b0;
        end else begin
            a_q     <= deb[P_A];
            btn_q   <= deb[P_BTN];
            pos     <= nxt;
            changed <= (nxt != pos);
            btn_evt <= btn_rise;
        end
    end
endmodule

// File: rtl/pmod_enc_bank.sv
// Bank of independent Pmod ENC channels; slices the packed per-channel
// parameters and ports into one enc_channel instance each.
module pmod_enc_bank
    import enc_pkg::*;
#(
    parameter int                      NUM_CH     = SCR_CH,
    parameter int                      WIDTH      = 8,
    parameter logic [NUM_CH*WIDTH-1:0] MAX_VAL    = SCR_MAX,
    parameter logic [NUM_CH*WIDTH-1:0] INIT_VAL   = '0,
    parameter logic [NUM_CH-1:0]       WRAP_MASK  = 3'b100,
    parameter int                      DEB_CYCLES = 5000,
    parameter int                      FAST_STEP  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         enc_a,
    input  logic [NUM_CH-1:0]         enc_b,
    input  logic [NUM_CH-1:0]         enc_btn,
    input  logic [NUM_CH-1:0]         enc_swt,
    output logic [NUM_CH*WIDTH-1:0]   pos,
    output logic [NUM_CH-1:0]         changed,
    output logic [NUM_CH-1:0]         btn_evt
);
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        enc_channel #(
            .WIDTH      (WIDTH),
            .MAX        (MAX_VAL[ch*WIDTH +: WIDTH]),
            .INIT       (INIT_VAL[ch*WIDTH +: WIDTH]),
            .WRAP       (WRAP_MASK[ch]),
            .DEB_CYCLES (DEB_CYCLES),
            .FAST_STEP  (FAST_STEP)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .a       (enc_a[ch]),
            .b       (enc_b[ch]),
            .btn     (enc_btn[ch]),
            .swt     (enc_swt[ch]),
            .pos     (pos[ch*WIDTH +: WIDTH]),
            .changed (changed[ch]),
            .btn_evt (btn_evt[ch])
        );
    end
endmodule

// File: tb/tb_pmod_enc_bank.sv
// Directed and randomized bench for pmod_enc_bank (DEB_CYCLES = 4), compared
// against a plain-arithmetic position model per channel.
module tb_pmod_enc_bank;
    localparam int NCH = 3;
    localparam int W   = 8;
    localparam int LAT = 7; // DEB_CYCLES + 3

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH-1:0]   enc_a, enc_b, enc_btn, enc_swt;
    logic [NCH*W-1:0] pos;
    logic [NCH-1:0]   changed, btn_evt;

    int checks   = 0;
    int failures = 0;
    int mpos[NCH];
    int mmax[NCH]  = '{159, 119, 255};
    bit mwrap[NCH] = '{1'b0, 1'b0, 1'b1};

    pmod_enc_bank #(
        .NUM_CH     (NCH),
        .WIDTH      (W),
        .MAX_VAL    ({8'd255, 8'd119, 8'd159}),
        .INIT_VAL   ('0),
        .WRAP_MASK  (3'b100),
        .DEB_CYCLES (4),
        .FAST_STEP  (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enc_a   (enc_a),
        .enc_b   (enc_b),
        .enc_btn (enc_btn),
        .enc_swt (enc_swt),
        .pos     (pos),
        .changed (changed),
        .btn_evt (btn_evt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_step(input int p, input int m, input bit wrap, input bit dec, input int s);
        int v;
        v = dec ? p - s : p + s;
        if (wrap) return (v + m + 1) % (m + 1);
        if (v > m) return m;
        if (v < 0) return 0;
        return v;
    endfunction

    task automatic check_all(input string tag);
        for (int c = 0; c < NCH; c++)
            chk($sformatf("%s_pos%0d", tag, c), 32'(pos[c*W +: W]), 32'(mpos[c]));
    endtask

    // Set direction/speed, raise A (and optionally BTN) for `hold` cycles, and
    // expect any change exactly LAT cycles after the pin edge.
    task automatic step(input int ch, input bit dec, input bit fast, input bit with_btn, input int hold);
        int exp;
        logic [NCH-1:0] chg_exp, evt_exp;
        enc_b[ch]   = dec;
        enc_swt[ch] = fast;
        repeat (8) @(negedge clk);
        exp = with_btn ? 0 : model_step(mpos[ch], mmax[ch], mwrap[ch], dec, fast ? 8 : 1);
        enc_a[ch] = 1'b1;
        if (with_btn) enc_btn[ch] = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == hold) begin
                enc_a[ch]   = 1'b0;
                enc_btn[ch] = 1'b0;
            end
            chg_exp = '0;
            evt_exp = '0;
            if (c == LAT) begin
                chg_exp[ch] = (exp != mpos[ch]);
                evt_exp[ch] = with_btn;
            end
            chk($sformatf("changed_ch%0d_c%0d", ch, c), 32'(changed), 32'(chg_exp));
            chk($sformatf("btn_evt_ch%0d_c%0d", ch, c), 32'(btn_evt), 32'(evt_exp));
        end
        mpos[ch] = exp;
        check_all("step");
        enc_a[ch]   = 1'b0;
        enc_btn[ch] = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("changed_release", 32'(changed), 32'(0));
        end
    endtask

    task automatic goto_up(input int ch, input int tgt);
        while (mpos[ch] < tgt)
            step(ch, 1'b0, (tgt - mpos[ch]) >= 8, 1'b0, 12);
    endtask

    initial begin
        rst = 1'b1;
        enc_a = '0; enc_b = '0; enc_btn = '0; enc_swt = '0;
        for (int c = 0; c < NCH; c++) mpos[c] = 0;
        repeat (3) @(negedge clk);
        check_all("reset");
        chk("reset_changed", 32'(changed), 32'(0));
        chk("reset_btn_evt", 32'(btn_evt), 32'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Three slow increments on channel 0.
        repeat (3) step(0, 1'b0, 1'b0, 1'b0, 12);

        // 3-cycle bounce on A: no step.
        enc_a[0] = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 3) enc_a[0] = 1'b0;
            chk("bounce_changed", 32'(changed), 32'(0));
        end
        check_all("bounce");
        // 4-cycle stable pulse: exactly one step.
        step(0, 1'b0, 1'b0, 1'b0, 4);

        // Saturation at MAX on channel 0.
        goto_up(0, 158);
        step(0, 1'b0, 1'b1, 1'b0, 12);
        chk("sat_159", 32'(pos[0 +: W]), 32'(159));
        step(0, 1'b0, 1'b0, 1'b0, 12);

        // Wrap channel: 0 -> 255 -> 254 -> 253, fast inc -> 5, BTN -> 0, dec -> 255.
        repeat (3) step(2, 1'b1, 1'b0, 1'b0, 12);
        chk("wrap_253", 32'(pos[2*W +: W]), 32'(253));
        step(2, 1'b0, 1'b1, 1'b0, 12);
        chk("wrap_5", 32'(pos[2*W +: W]), 32'(5));
        step(2, 1'b1, 1'b0, 1'b1, 12);
        step(2, 1'b1, 1'b0, 1'b0, 12);
        chk("wrap_255", 32'(pos[2*W +: W]), 32'(255));

        // Saturating decrement at 0 on channel 1, then BTN and A together at 50.
        step(1, 1'b1, 1'b1, 1'b0, 12);
        goto_up(1, 50);
        step(1, 1'b0, 1'b0, 1'b1, 12);
        chk("btn_wins", 32'(pos[W +: W]), 32'(0));

        // Randomized steps across all channels.
        for (int n = 0; n < 40; n++)
            step($urandom_range(0, NCH-1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 7) == 0, 12);

        // Reset in the middle of a debounce window.
        step(1, 1'b0, 1'b1, 1'b0, 12);
        enc_b = '0; enc_swt = '0;
        repeat (8) @(negedge clk);
        enc_a[0] = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        for (int c = 0; c < NCH; c++) mpos[c] = 0;
        check_all("async_rst");
        chk("async_rst_changed", 32'(changed), 32'(0));
        enc_a[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            chk("post_rst_changed", 32'(changed), 32'(0));
        end
        check_all("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
